// File: rtl/reaction_pkg.sv
// Shared types for the reaction-timer controller and the display mux:
// state encoding and the LFSR feedback taps.
package reaction_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_FOUL    = 3'd4,
    ST_TIMEOUT = 3'd5
  } rt_state_t;

  // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] value);
    return {value[14:0], ^(value & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/reaction_timer_ctrl_if.sv
// Button/tick inputs and counter/status outputs of the reaction-timer controller.
interface reaction_timer_ctrl_if;
  import reaction_pkg::*;

  logic      start;
  logic      stop;
  logic      tick;
  logic      count_en;
  logic      cnt_clr;
  logic      go_led;
  logic      foul;
  logic      timeout;
  logic      busy;
  rt_state_t state;

  modport master (
    output start, stop, tick,
    input  count_en, cnt_clr, go_led, foul, timeout, busy, state
  );

  modport slave (
    input  start, stop, tick,
    output count_en, cnt_clr, go_led, foul, timeout, busy, state
  );

endinterface

// File: rtl/rt_lfsr.sv
// Free-running 16-bit Fibonacci LFSR used to randomise the hold-off delay.
module rt_lfsr
  import reaction_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] o_value
);

  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign o_value = r_lfsr;

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer sequencer: random hold-off, gated 1 ms counting, foul and
// timeout detection. Reset is asynchronous and active-low.
module reaction_timer_ctrl
  import reaction_pkg::*;
#(
  parameter int          DELAY_MIN_MS    = 1000,
  parameter int          DELAY_SPAN_LOG2 = 11,
  parameter int          TIMEOUT_MS      = 9999,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input logic                 clk,
  input logic                 reset,
  reaction_timer_ctrl_if.slave bus
);

  localparam int DELAY_W = $clog2(DELAY_MIN_MS + 2**DELAY_SPAN_LOG2);
  localparam int MS_W    = $clog2(TIMEOUT_MS + 1);

  rt_state_t          r_state;
  rt_state_t          w_state_next;
  logic [DELAY_W-1:0] r_delay_cnt;
  logic [DELAY_W-1:0] w_delay_next;
  logic [DELAY_W-1:0] w_delay_load;
  logic [MS_W-1:0]    r_ms_cnt;
  logic [MS_W-1:0]    w_ms_next;
  logic               r_cnt_clr;
  logic               w_cnt_clr_next;
  logic               w_count_en;
  logic               r_go_led;
  logic               r_foul;
  logic               r_timeout;
  logic               r_busy;
  logic [15:0]        w_lfsr;
  logic               w_unused_lfsr;

  rt_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .o_value(w_lfsr)
  );

  // Only the low bits feed the delay; the rest keep the sequence long.
  assign w_unused_lfsr = ^w_lfsr;
  assign w_delay_load  = DELAY_W'(DELAY_MIN_MS) + DELAY_W'(w_lfsr[DELAY_SPAN_LOG2-1:0]);

  always_comb begin
    w_state_next   = r_state;
    w_delay_next   = r_delay_cnt;
    w_ms_next      = r_ms_cnt;
    w_cnt_clr_next = 1'b0;
    w_count_en     = 1'b0;
    case (r_state)
      ST_WAIT: begin
        if (bus.stop) begin
          w_state_next = ST_FOUL;
        end else if (bus.tick) begin
          w_delay_next = r_delay_cnt - DELAY_W'(1);
          if (r_delay_cnt == DELAY_W'(1)) begin
            w_state_next = ST_RUN;
            w_ms_next    = '0;
          end
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          w_state_next = ST_DONE;
        end else if (bus.tick) begin
          w_count_en = 1'b1;
          w_ms_next  = r_ms_cnt + MS_W'(1);
          if (r_ms_cnt == MS_W'(TIMEOUT_MS - 1)) begin
            w_state_next = ST_TIMEOUT;
          end
        end
      end
      // Idle and every terminal state re-arm identically on start.
      ST_IDLE, ST_DONE, ST_FOUL, ST_TIMEOUT: begin
        if (bus.start) begin
          w_state_next   = ST_WAIT;
          w_cnt_clr_next = 1'b1;
          w_delay_next   = w_delay_load;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_delay_cnt <= '0;
      r_ms_cnt    <= '0;
      r_cnt_clr   <= 1'b0;
      r_go_led    <= 1'b0;
      r_foul      <= 1'b0;
      r_timeout   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_delay_cnt <= w_delay_next;
      r_ms_cnt    <= w_ms_next;
      r_cnt_clr   <= w_cnt_clr_next;
      r_go_led    <= (w_state_next == ST_RUN);
      r_foul      <= (w_state_next == ST_FOUL);
      r_timeout   <= (w_state_next == ST_TIMEOUT);
      r_busy      <= (w_state_next == ST_WAIT) || (w_state_next == ST_RUN);
    end
  end

  assign bus.count_en = w_count_en;
  assign bus.cnt_clr  = r_cnt_clr;
  assign bus.go_led   = r_go_led;
  assign bus.foul     = r_foul;
  assign bus.timeout  = r_timeout;
  assign bus.busy     = r_busy;
  assign bus.state    = r_state;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Bench for reaction_timer_ctrl: directed scenarios plus random button
// traffic, checked cycle by cycle against a behavioural reference model.
module tb_reaction_timer_ctrl;

  localparam int          DelayMin  = 4;
  localparam int          SpanLog2  = 2;
  localparam int          TimeoutMs = 20;
  localparam logic [15:0] Seed      = 16'hACE1;

  localparam int sIdle = 0, sWait = 1, sRun = 2, sDone = 3, sFoul = 4, sTimeout = 5;

  logic clock = 1'b0;
  logic resetN;

  always #5 clock = ~clock;

  reaction_timer_ctrl_if bus();

  reaction_timer_ctrl #(
    .DELAY_MIN_MS   (DelayMin),
    .DELAY_SPAN_LOG2(SpanLog2),
    .TIMEOUT_MS     (TimeoutMs),
    .LFSR_SEED      (Seed)
  ) dut (
    .clk  (clock),
    .reset(resetN),
    .bus  (bus)
  );

  int          assertCount = 0;
  int          failCount   = 0;
  int          mState;
  int          mTicksLeft;
  int          mMs;
  logic [15:0] mLfsr;
  int          tickPhase;
  bit          expClr;
  int          obsPulses;
  int          obsGoHigh;

  // Reference LFSR: shift left, new bit = b16 ^ b14 ^ b13 ^ b11 (1-based taps)
  function automatic logic [15:0] lfsrStep(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".state"},   32'(bus.state),   32'(mState));
    checkValue({tag, ".cnt_clr"}, 32'(bus.cnt_clr), 32'(expClr));
    checkValue({tag, ".go_led"},  32'(bus.go_led),  32'(mState == sRun));
    checkValue({tag, ".foul"},    32'(bus.foul),    32'(mState == sFoul));
    checkValue({tag, ".timeout"}, 32'(bus.timeout), 32'(mState == sTimeout));
    checkValue({tag, ".busy"},    32'(bus.busy),    32'(mState == sWait || mState == sRun));
  endtask

  // One clock cycle: drive buttons, check count_en before the edge, advance
  // the model, then check the registered outputs after the edge.
  task automatic applyStimulus(input bit s, input bit p);
    bit tickNow;
    bit accepted;
    tickNow   = (tickPhase == 0);
    tickPhase = (tickPhase + 1) % 5;
    bus.start = s;
    bus.stop  = p;
    bus.tick  = tickNow;
    #2;
    checkValue("count_en", 32'(bus.count_en), 32'(mState == sRun && tickNow && !p));
    if (bus.count_en === 1'b1) obsPulses++;
    accepted = 1'b0;
    case (mState)
      sWait: begin
        if (p) mState = sFoul;
        else if (tickNow) begin
          mTicksLeft--;
          if (mTicksLeft == 0) begin
            mState = sRun;
            mMs    = 0;
          end
        end
      end
      sRun: begin
        if (p) mState = sDone;
        else if (tickNow) begin
          mMs++;
          if (mMs == TimeoutMs) mState = sTimeout;
        end
      end
      default: begin
        if (s) begin
          mState     = sWait;
          mTicksLeft = DelayMin + int'(mLfsr[SpanLog2-1:0]);
          accepted   = 1'b1;
        end
      end
    endcase
    expClr = accepted;
    @(posedge clock);
    mLfsr = lfsrStep(mLfsr);
    #1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.tick  = 1'b0;
    checkOutput("cycle");
    if (bus.go_led === 1'b1) obsGoHigh++;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int waitTicks;
    int runTicks;

    resetN    = 1'b0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.tick  = 1'b0;
    mState    = sIdle;
    mTicksLeft = 0;
    mMs       = 0;
    mLfsr     = Seed;
    tickPhase = 0;
    expClr    = 1'b0;
    obsPulses = 0;
    obsGoHigh = 0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset");
    checkValue("reset.count_en", 32'(bus.count_en), 32'd0);
    checkValue("reset.lfsr", 32'(dut.w_lfsr), 32'(Seed));
    resetN = 1'b1;

    $display("[TB] idle after reset");
    repeat (50) applyStimulus(1'b0, 1'b0);
    checkValue("idle.pulses", 32'(obsPulses), 32'd0);

    $display("[TB] start with lfsr[1:0]=2, stop after 7 run ticks");
    n = 0;
    while (mLfsr[1:0] != 2'd2 && n < 200) begin
      applyStimulus(1'b0, 1'b0);
      n++;
    end
    checkValue("arm.lfsr_low", 32'(dut.w_lfsr[1:0]), 32'd2);
    applyStimulus(1'b1, 1'b0);
    checkValue("arm.cnt_clr", 32'(bus.cnt_clr), 32'd1);
    waitTicks = 0;
    n = 0;
    while (bus.state == 1 && n < 200) begin
      if (tickPhase == 0) waitTicks++;
      applyStimulus(1'b0, 1'b0);
      n++;
    end
    checkValue("wait.ticks", 32'(waitTicks), 32'd6);
    checkValue("run.go_led", 32'(bus.go_led), 32'd1);
    obsPulses = 0;
    runTicks  = 0;
    n = 0;
    while (runTicks < 7 && n < 100) begin
      if (tickPhase == 0) runTicks++;
      applyStimulus(1'b0, 1'b0);
      n++;
    end
    applyStimulus(1'b0, 1'b1);
    checkValue("done.state", 32'(bus.state), 32'd3);
    checkValue("done.pulses", 32'(obsPulses), 32'd7);
    applyStimulus(1'b0, 1'b1);

    $display("[TB] foul: stop coincident with a wait tick");
    applyStimulus(1'b1, 1'b0);
    checkValue("rearm.cnt_clr", 32'(bus.cnt_clr), 32'd1);
    obsPulses = 0;
    obsGoHigh = 0;
    while (tickPhase != 0) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkValue("foul.state", 32'(bus.state), 32'd4);
    checkValue("foul.flag", 32'(bus.foul), 32'd1);
    repeat (12) applyStimulus(1'b0, 1'b0);
    checkValue("foul.pulses", 32'(obsPulses), 32'd0);
    checkValue("foul.go_led_seen", 32'(obsGoHigh), 32'd0);

    $display("[TB] timeout: no stop during run");
    applyStimulus(1'b1, 1'b0);
    obsPulses = 0;
    n = 0;
    while (bus.state != 5 && n < 400) begin
      applyStimulus(1'b0, 1'b0);
      n++;
    end
    checkValue("timeout.state", 32'(bus.state), 32'd5);
    checkValue("timeout.flag", 32'(bus.timeout), 32'd1);
    checkValue("timeout.pulses", 32'(obsPulses), 32'd20);
    repeat (7) applyStimulus(1'b0, 1'b1);
    checkValue("timeout.hold", 32'(bus.state), 32'd5);

    $display("[TB] start+stop in terminal, start in run, stop on run tick");
    applyStimulus(1'b1, 1'b1);
    checkValue("both.state", 32'(bus.state), 32'd1);
    checkValue("both.cnt_clr", 32'(bus.cnt_clr), 32'd1);
    n = 0;
    while (bus.state == 1 && n < 200) begin
      applyStimulus(1'b0, 1'b0);
      n++;
    end
    applyStimulus(1'b1, 1'b0);
    checkValue("run_start.state", 32'(bus.state), 32'd2);
    checkValue("run_start.cnt_clr", 32'(bus.cnt_clr), 32'd0);
    repeat (8) applyStimulus(1'b0, 1'b0);
    while (tickPhase != 0) applyStimulus(1'b0, 1'b0);
    obsPulses = 0;
    applyStimulus(1'b0, 1'b1);
    checkValue("stop_tick.pulses", 32'(obsPulses), 32'd0);
    checkValue("stop_tick.state", 32'(bus.state), 32'd3);
    applyStimulus(1'b1, 1'b0);
    checkValue("from_done.state", 32'(bus.state), 32'd1);
    checkValue("from_done.cnt_clr", 32'(bus.cnt_clr), 32'd1);
    applyStimulus(1'b1, 1'b1);
    checkValue("wait_both.state", 32'(bus.state), 32'd4);

    $display("[TB] reset asserted mid-run");
    applyStimulus(1'b1, 1'b0);
    n = 0;
    while (bus.state == 1 && n < 200) begin
      applyStimulus(1'b0, 1'b0);
      n++;
    end
    repeat (6) applyStimulus(1'b0, 1'b0);
    while (tickPhase != 2) applyStimulus(1'b0, 1'b0);
    checkValue("pre_reset.state", 32'(bus.state), 32'd2);
    resetN = 1'b0;
    #1;
    checkValue("async_reset.state", 32'(bus.state), 32'd0);
    checkValue("async_reset.go_led", 32'(bus.go_led), 32'd0);
    checkValue("async_reset.busy", 32'(bus.busy), 32'd0);
    checkValue("async_reset.count_en", 32'(bus.count_en), 32'd0);
    @(posedge clock);
    #1;
    resetN = 1'b1;
    mState = sIdle;
    mLfsr  = Seed;
    expClr = 1'b0;
    checkValue("post_reset.lfsr", 32'(dut.w_lfsr), 32'(Seed));
    checkOutput("post_reset");

    $display("[TB] random button traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(bit'($urandom_range(0, 15) == 0), bit'($urandom_range(0, 19) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
